stopwatch_ctrl_fsm: RTL and testbench

Control FSM for the stopwatch datapath. It takes three raw push-button inputs (start, stop, reset), synchronises, debounces and edge-detects each one, and produces the 3-bit one-hot run state consumed by the state-decoder/time-counter stage directly downstream. It is the only source of that state bus.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 79 +++++++
 rtl/stopwatch_ctrl_fsm.sv | 111 +++++++++++
 tb/tb_stopwatch_ctrl_fsm.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path: one-hot run-state codes and
// counter sizing helper. Also imported by the downstream state decoder.
package stopwatch_pkg;

    // One-hot run-state codes as seen on the state bus.
    localparam logic [2:0] ST_RESET = 3'b100;
    localparam logic [2:0] ST_STOP  = 3'b010;
    localparam logic [2:0] ST_START = 3'b001;

    typedef enum logic [2:0] {
        StReset = ST_RESET,
        StStop  = ST_STOP,
        StStart = ST_START
    } run_state_e;

    // Bits needed to hold a count from 0 up to and including max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button input chain: 2-flop synchroniser, optional debouncer, rising-edge detect.
// Debouncer is present only when STOPWATCH_CTRL_DEBOUNCE_EN is defined; otherwise the
// debounced level is a registered copy of the synchroniser output.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_cycles
        $error("btn_debounce: DEBOUNCE_CYCLES out of range");
    end

    logic sync1_q;
    logic sync2_q;
    logic db_q;
    logic db_prev_q;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [CntW-1:0] cnt_q;

    // Count mismatching cycles; adopt the synchronised level once the count hits the limit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (sync2_q == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    // No filtering: keep one register stage so the edge detect sees the same structure.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            db_q <= 1'b0;
        end else begin
            db_q <= sync2_q;
        end
    end
`endif

    // Previous debounced level for the rising-edge detect.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            db_prev_q <= 1'b0;
        end else begin
            db_prev_q <= db_q;
        end
    end

    assign o_level = db_q;
    assign o_press = db_q & ~db_prev_q;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch run-state controller: conditions three push buttons and drives the one-hot
// RESET/STOP/START state bus. Debouncing is enabled by STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl_fsm
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RESET_HOLD      = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_start,
    input  logic       i_btn_stop,
    input  logic       i_btn_reset,
    output logic [2:0] o_state,
    output logic [2:0] o_btn_db
);

    if (RESET_HOLD < 1) begin : g_bad_hold
        $error("stopwatch_ctrl_fsm: RESET_HOLD must be at least 1");
    end

    localparam int unsigned HoldW = cnt_width(RESET_HOLD);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(RESET_HOLD);

    logic lvl_start, lvl_stop, lvl_reset;
    logic press_start, press_stop, press_reset;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_start (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_start),
        .o_level (lvl_start),
        .o_press (press_start)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_stop (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_stop),
        .o_level (lvl_stop),
        .o_press (press_stop)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_reset (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_reset),
        .o_level (lvl_reset),
        .o_press (press_reset)
    );

    run_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;

    // State and hold-counter registers; i_reset overrides any press in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StReset;
            hold_q  <= HoldMax;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: reset press first, then per-state rules; stop beats start.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (press_reset) begin
            state_d = StReset;
            hold_d  = HoldMax;
        end else begin
            case (state_q)
                StReset: begin
                    // Presses during the hold are dropped, not queued.
                    if (hold_q <= HoldW'(1)) begin
                        state_d = StStop;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                StStop: begin
                    if (!press_stop && press_start) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (press_stop) begin
                        state_d = StStop;
                    end
                end
                default: begin
                    // Non-one-hot value: recover through RESET.
                    state_d = StReset;
                    hold_d  = HoldMax;
                end
            endcase
        end
    end

    assign o_state  = state_q;
    assign o_btn_db = {lvl_reset, lvl_stop, lvl_start};

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Bench for stopwatch_ctrl_fsm: directed scenarios with fixed edge-count expectations,
// then randomized button activity checked cycle by cycle against a behavioural model.
// Works with STOPWATCH_CTRL_DEBOUNCE_EN defined or undefined.
module tb_stopwatch_ctrl_fsm;
    import stopwatch_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned RH = 2;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b_start = 1'b0;
    logic       b_stop = 1'b0;
    logic       b_reset = 1'b0;
    logic [2:0] o_state;
    logic [2:0] o_btn_db;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl_fsm #(
        .DEBOUNCE_CYCLES (DB),
        .RESET_HOLD      (RH)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_btn_start (b_start),
        .i_btn_stop  (b_stop),
        .i_btn_reset (b_reset),
        .o_state     (o_state),
        .o_btn_db    (o_btn_db)
    );

    // Behavioural model: raw samples pass through two sample delays, a level flips once
    // it has disagreed for DB+1 consecutive samples, presses are new high levels.
    localparam int MS_RESET = 0;
    localparam int MS_STOP  = 1;
    localparam int MS_START = 2;

    logic [2:0] m_s1, m_s2, m_db, m_dbp;
    int         m_st;
    int         m_elapsed;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    int         m_run [3];
`endif

    function automatic logic [2:0] oh(input int st);
        return (st == MS_RESET) ? ST_RESET : (st == MS_STOP) ? ST_STOP : ST_START;
    endfunction

    task automatic model_step(input logic [2:0] raw, input logic r);
        logic [2:0] press;
        press = m_db & ~m_dbp;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
            for (int b = 0; b < 3; b++) m_run[b] = 0;
`endif
            m_st = MS_RESET;
            m_elapsed = 0;
            return;
        end
        if (press[2]) begin
            m_st = MS_RESET;
            m_elapsed = 0;
        end else if (m_st == MS_RESET) begin
            m_elapsed++;
            if (m_elapsed >= int'(RH)) m_st = MS_STOP;
        end else if (m_st == MS_STOP) begin
            if (press[0] && !press[1]) m_st = MS_START;
        end else if (press[1]) begin
            m_st = MS_STOP;
        end
        for (int b = 0; b < 3; b++) begin
            m_dbp[b] = m_db[b];
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
            if (m_s2[b] != m_db[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == int'(DB) + 1) begin
                m_db[b] = m_s2[b];
                m_run[b] = 0;
            end
`else
            m_db[b] = m_s2[b];
`endif
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Single-cycle i_reset; returns having observed the reset edge.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        b_start = 0; b_stop = 0; b_reset = 0;
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            exp = (k < int'(RH)) ? ST_RESET : ST_STOP;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL reset_hold k=%0d state=%b expected=%b", k, o_state, exp);
            end
            vectors++;
            if (o_btn_db !== 3'b000) begin
                errors++;
                $display("FAIL reset_db k=%0d db=%b expected=000", k, o_btn_db);
            end
        end
    endtask

    task automatic test_start_stop();
        logic [2:0] exp;
        logic       exp_db;
        b_start = 1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            exp = (k < LAT) ? ST_STOP : ST_START;
            exp_db = (k >= LAT - 1);
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL start_press edge=%0d state=%b expected=%b", k, o_state, exp);
            end
            vectors++;
            if (o_btn_db[0] !== exp_db) begin
                errors++;
                $display("FAIL start_db edge=%0d db=%b expected=%b", k, o_btn_db[0], exp_db);
            end
        end
        b_start = 0;
        wait_neg(LAT + 2);
        b_start = 1;
        wait_neg(LAT + 2);
        vectors++;
        if (o_state !== ST_START) begin
            errors++;
            $display("FAIL start_in_start state=%b expected=%b", o_state, ST_START);
        end
        b_start = 0;
        wait_neg(LAT + 2);
        b_stop = 1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            exp = (k < LAT) ? ST_START : ST_STOP;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL stop_press edge=%0d state=%b expected=%b", k, o_state, exp);
            end
        end
        b_stop = 0;
        wait_neg(LAT + 2);
    endtask

    task automatic test_glitch();
        logic [2:0] exp;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
        b_start = 1;
        wait_neg(int'(DB) - 1);
        b_start = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            vectors++;
            if (o_btn_db[0] !== 1'b0 || o_state !== ST_STOP) begin
                errors++;
                $display("FAIL glitch_reject k=%0d db=%b state=%b expected db=0 state=%b",
                         k, o_btn_db[0], o_state, ST_STOP);
            end
        end
        // Long enough to survive the filter; released before the state changes.
        b_start = 1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            if (k == int'(DB) + 1) b_start = 0;
            exp = (k < LAT) ? ST_STOP : ST_START;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL glitch_accept edge=%0d state=%b expected=%b", k, o_state, exp);
            end
        end
`else
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            exp = (k < LAT) ? ST_STOP : ST_START;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL short_pulse edge=%0d state=%b expected=%b", k, o_state, exp);
            end
        end
`endif
        b_start = 0;
        wait_neg(LAT + 2);
        b_stop = 1;
        wait_neg(LAT + 1);
        b_stop = 0;
        wait_neg(LAT + 2);
        vectors++;
        if (o_state !== ST_STOP) begin
            errors++;
            $display("FAIL glitch_restore state=%b expected=%b", o_state, ST_STOP);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp;
        // start + stop together in START: stop wins
        b_start = 1; wait_neg(LAT + 1); b_start = 0; wait_neg(LAT + 2);
        b_start = 1; b_stop = 1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            exp = (k < LAT) ? ST_START : ST_STOP;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL start_and_stop edge=%0d state=%b expected=%b", k, o_state, exp);
            end
        end
        b_start = 0; b_stop = 0; wait_neg(LAT + 2);
        // reset + stop together in START: reset wins, held button gives no repeat press
        b_start = 1; wait_neg(LAT + 1); b_start = 0; wait_neg(LAT + 2);
        b_reset = 1; b_stop = 1;
        for (int k = 0; k <= LAT + 4; k++) begin
            @(negedge clk);
            exp = (k < LAT) ? ST_START : (k < LAT + int'(RH)) ? ST_RESET : ST_STOP;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL reset_and_stop edge=%0d state=%b expected=%b", k, o_state, exp);
            end
        end
        b_reset = 0; b_stop = 0; wait_neg(LAT + 2);
        // start press landing inside the RESET hold is dropped
        b_reset = 1;
        @(negedge clk);
        b_start = 1;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            exp = (k < LAT) ? ST_STOP : (k < LAT + int'(RH)) ? ST_RESET : ST_STOP;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL start_in_hold edge=%0d state=%b expected=%b", k, o_state, exp);
            end
        end
        vectors++;
        if (o_btn_db !== 3'b101) begin
            errors++;
            $display("FAIL held_levels db=%b expected=101", o_btn_db);
        end
        b_reset = 0; b_start = 0; wait_neg(LAT + 2);
    endtask

    task automatic test_reset_mid_debounce();
        logic [2:0] exp;
        b_start = 1;
        wait_neg(3);
        rst = 1;
        @(negedge clk);
        rst = 0;
        vectors++;
        if (o_state !== ST_RESET || o_btn_db !== 3'b000) begin
            errors++;
            $display("FAIL mid_debounce_reset state=%b db=%b expected state=%b db=000",
                     o_state, o_btn_db, ST_RESET);
        end
        // Held button is re-sampled from the edge after reset: new press at 4+LAT.
        for (int k = 4; k <= LAT + 5; k++) begin
            @(negedge clk);
            exp = (k < 3 + int'(RH)) ? ST_RESET : (k < 4 + LAT) ? ST_STOP : ST_START;
            vectors++;
            if (o_state !== exp) begin
                errors++;
                $display("FAIL mid_debounce edge=%0d state=%b expected=%b", k, o_state, exp);
            end
        end
        b_start = 0;
        wait_neg(LAT + 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) b_start = ~b_start;
            if ($urandom_range(0, 11) == 0) b_stop = ~b_stop;
            if ($urandom_range(0, 39) == 0) b_reset = ~b_reset;
            @(negedge clk);
            model_step({b_reset, b_stop, b_start}, rst);
            vectors++;
            if (o_state !== oh(m_st)) begin
                errors++;
                $display("FAIL random_state cycle=%0d state=%b expected=%b", i, o_state, oh(m_st));
            end
            vectors++;
            if (o_btn_db !== m_db) begin
                errors++;
                $display("FAIL random_db cycle=%0d db=%b expected=%b", i, o_btn_db, m_db);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_glitch();
        test_simultaneous();
        test_reset_mid_debounce();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
